// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter device:
// register word offsets, STATUS/CTRL bit positions and FSM states.
package uart_tx_pkg;

  localparam logic [7:0] REG_TXDATA = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_CLKDIV = 8'h02;
  localparam logic [7:0] REG_CTRL   = 8'h03;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_PAR_EN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART shifter.
// Pushes to a full FIFO and pops from an empty one are ignored.
module uart_tx_fifo #(
  parameter int Depth = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             wdata,
  input  logic                   pop,
  output logic [7:0]             rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] level
);

  localparam int Aw = $clog2(Depth);

  logic [7:0]    mem [Depth];
  logic [Aw-1:0] wr_ptr;
  logic [Aw-1:0] rd_ptr;
  logic [Aw:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == Aw'(0) + (Aw+1)'(Depth));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_device.sv
// Memory-mapped UART transmitter (8N1, optional even parity
// when UART_TX_PARITY_EN is defined) on the simple-system bus.
module uart_tx_device
  import uart_tx_pkg::*;
#(
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] ClkDivReset  = 16'd433,
  parameter int          AddressWidth = 32,
  parameter int          DataWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic                    tx_o,
  output logic                    irq_o
);

  logic [7:0]  idx;
  logic        push, pop, full, empty;
  logic [7:0]  fifo_rdata;
  logic [$clog2(FifoDepth):0] level;
  logic        err_d, div_we, ctrl_we;
  logic [31:0] rdata_d, status, ctrl_rd;
  logic [15:0] clkdiv_q;
  logic        tx_en_q, irq_en_q, par_en;
  logic        busy, tick, can_go;
  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        unused_bits;

  assign unused_bits = ^{addr_i[AddressWidth-1:10], addr_i[1:0],
                         be_i[3:2], wdata_i[DataWidth-1:16]};

  uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (wdata_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign idx    = addr_i[9:2];
  assign busy   = (state_q != S_IDLE);
  assign status = {16'b0, 8'(level), 5'b0, busy, empty, full};

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  assign par_en  = par_en_q;
`else
  assign par_en  = 1'b0;
`endif
  assign ctrl_rd = {29'b0, par_en, irq_en_q, tx_en_q};

  // Full is judged on the pre-cycle state, so a same-cycle pop never rescues a push.
  always_comb begin
    push    = 1'b0;
    err_d   = 1'b0;
    div_we  = 1'b0;
    ctrl_we = 1'b0;
    rdata_d = '0;
    if (req_i) begin
      unique case (1'b1)
        idx == REG_TXDATA: begin
          if (we_i && be_i[0]) begin
            if (full) err_d = 1'b1;
            else      push  = 1'b1;
          end
        end
        idx == REG_STATUS: begin
          if (we_i) err_d   = 1'b1;
          else      rdata_d = status;
        end
        idx == REG_CLKDIV: begin
          if (we_i) div_we  = 1'b1;
          else      rdata_d = {16'b0, clkdiv_q};
        end
        idx == REG_CTRL: begin
          if (we_i) ctrl_we = 1'b1;
          else      rdata_d = ctrl_rd;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      clkdiv_q <= ClkDivReset;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= DataWidth'(rdata_d);
      err_o    <= err_d;
      if (div_we && be_i[0]) clkdiv_q[7:0]  <= wdata_i[7:0];
      if (div_we && be_i[1]) clkdiv_q[15:8] <= wdata_i[15:8];
      if (ctrl_we && be_i[0]) begin
        tx_en_q  <= wdata_i[CTRL_TX_EN];
        irq_en_q <= wdata_i[CTRL_IRQ_EN];
      end
      irq_o <= irq_en_q && empty && !busy;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     par_en_q <= 1'b0;
    else if (ctrl_we && be_i[0])   par_en_q <= wdata_i[CTRL_PAR_EN];
  end
`endif

  assign tick   = (cnt_q == '0);
  assign can_go = tx_en_q && !empty;

  // Bit timer reloads from CLKDIV at each boundary, so CLKDIV edits land on the next bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    if (state_q != S_IDLE) cnt_d = tick ? clkdiv_q : cnt_q - 16'd1;
    unique case (state_q)
      S_IDLE: begin
        if (can_go) begin
          pop     = 1'b1;
          state_d = S_START;
          shift_d = fifo_rdata;
          par_d   = ^fifo_rdata;
          cnt_d   = clkdiv_q;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
            state_d = par_en ? S_PARITY : S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          if (can_go) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = fifo_rdata;
            par_d   = ^fifo_rdata;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      S_START:  tx_o = 1'b0;
      S_DATA:   tx_o = shift_q[0];
      S_PARITY: tx_o = par_q;
      default:  tx_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_device.sv
// Directed bench for uart_tx_device: bus responses and serial
// frames are checked against queues filled as stimulus is driven.
module tb_uart_tx_device;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        tx;
  logic        irq;

  always #5 clk = ~clk;

  uart_tx_device dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .we_i     (we),
    .be_i     (be),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .tx_o     (tx),
    .irq_o    (irq)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [7:0] byte_q[$];
  int         total = 0;
  int         bad = 0;
  int         bt = 434;
  bit         mon_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err);
    rsp_t r;
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    r.rdata = exp_rd; r.err = exp_err; r.tag = tag;
    rsp_q.push_back(r);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
  endtask

  initial begin : bus_mon
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rvalid), 32'd0);
      end else if (rvalid === 1'b1) begin
        r = rsp_q.pop_front();
        chk({r.tag, "_rdata"}, rdata, r.rdata);
        chk({r.tag, "_err"}, 32'(err), 32'(r.err));
      end
    end
  end

  initial begin : ser_mon
    logic [9:0] bits;
    int off;
    int tgt;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (mon_en && rst === 1'b0 && tx === 1'b0) begin
        off = 0;
        for (int k = 0; k < 10; k++) begin
          tgt = k * bt + bt / 2;
          while (off < tgt) begin
            @(negedge clk);
            off++;
          end
          bits[k] = tx;
        end
        chk("frame_start", 32'(bits[0]), 32'd0);
        chk("frame_stop", 32'(bits[9]), 32'd1);
        if (byte_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL frame_unexpected: got %h want none", bits[8:1]);
        end else begin
          exp_b = byte_q.pop_front();
          chk("frame_data", 32'(bits[8:1]), 32'(exp_b));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fa;
    logic [7:0] fb;
    logic [7:0] cur;
    logic       e;
    int         f;
    int         b;
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0;
    addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;

    bus("rd_status", 1'b0, 4'hf, 32'h4, 32'h0, 32'h2, 1'b0);
    bus("rd_clkdiv", 1'b0, 4'hf, 32'h8, 32'h0, 32'd433, 1'b0);
    bus("rd_ctrl", 1'b0, 4'hf, 32'hc, 32'h0, 32'h0, 1'b0);
    bus("rd_txdata", 1'b0, 4'hf, 32'h0, 32'h0, 32'h0, 1'b0);

    bus("wr_div3", 1'b1, 4'h3, 32'h8, 32'h3, 32'h0, 1'b0);
    bt = 4;
    bus("wr_ctrl1", 1'b1, 4'hf, 32'hc, 32'h1, 32'h0, 1'b0);
    byte_q.push_back(8'h55);
    bus("wr_tx55", 1'b1, 4'hf, 32'h0, 32'h55, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = ((i / 4) % 2) == 1;
      chk("t2_bit", 32'(tx), 32'(e));
    end
    @(negedge clk);
    chk("t2_idle", 32'(tx), 32'd1);

    bus("wr_ctrl0", 1'b1, 4'hf, 32'hc, 32'h0, 32'h0, 1'b0);
    bus("wr_div0", 1'b1, 4'h3, 32'h8, 32'h0, 32'h0, 1'b0);
    bt = 1;
    fa = 8'ha3;
    fb = 8'h3c;
    byte_q.push_back(fa);
    bus("wr_txa", 1'b1, 4'h1, 32'h0, 32'ha3, 32'h0, 1'b0);
    byte_q.push_back(fb);
    bus("wr_txb", 1'b1, 4'h1, 32'h0, 32'h3c, 32'h0, 1'b0);
    bus("wr_ctrl3", 1'b1, 4'hf, 32'hc, 32'h3, 32'h0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      f = i / 10;
      b = i % 10;
      cur = (f == 0) ? fa : fb;
      if (i >= 20)     e = 1'b1;
      else if (b == 0) e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = cur[b-1];
      chk("t5_bit", 32'(tx), 32'(e));
      chk("t5_irq", 32'(irq), 32'(i >= 21));
    end

    bus("rd_bad", 1'b0, 4'hf, 32'h10, 32'h0, 32'h0, 1'b1);
    bus("wr_status", 1'b1, 4'hf, 32'h4, 32'hffff, 32'h0, 1'b1);
    bus("wr_bad", 1'b1, 4'hf, 32'h10, 32'h1234, 32'h0, 1'b1);
    bus("rd_div_kept", 1'b0, 4'hf, 32'h8, 32'h0, 32'h0, 1'b0);
    bus("rd_ctrl_kept", 1'b0, 4'hf, 32'hc, 32'h0, 32'h3, 1'b0);
    bus("rd_stat_kept", 1'b0, 4'hf, 32'h4, 32'h0, 32'h2, 1'b0);

    bus("wr_ctrl_off", 1'b1, 4'hf, 32'hc, 32'h0, 32'h0, 1'b0);
    bus("wr_div3b", 1'b1, 4'h3, 32'h8, 32'h3, 32'h0, 1'b0);
    bt = 4;
    for (int i = 0; i < 8; i++) begin
      bus("fill", 1'b1, 4'hf, 32'h0, 32'h10 + 32'(i), 32'h0, 1'b0);
    end
    bus("rd_stat_full", 1'b0, 4'hf, 32'h4, 32'h0, 32'h0801, 1'b0);
    bus("wr_nobe", 1'b1, 4'he, 32'h0, 32'h99, 32'h0, 1'b0);
    bus("wr_overflow", 1'b1, 4'hf, 32'h0, 32'h99, 32'h0, 1'b1);
    bus("rd_stat_full2", 1'b0, 4'hf, 32'h4, 32'h0, 32'h0801, 1'b0);

    mon_en = 1'b0;
    bus("wr_ctrl_go", 1'b1, 4'hf, 32'hc, 32'h1, 32'h0, 1'b0);
    repeat (10) @(negedge clk);
    chk("t6_pre_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_tx", 32'(tx), 32'd1);
    chk("t6_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus("t6_status", 1'b0, 4'hf, 32'h4, 32'h0, 32'h2, 1'b0);
    bus("t6_clkdiv", 1'b0, 4'hf, 32'h8, 32'h0, 32'd433, 1'b0);
    bus("t6_ctrl", 1'b0, 4'hf, 32'hc, 32'h0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_idle_tx", 32'(tx), 32'd1);

    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("byte_q_empty", 32'(byte_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
